pipe_ctrl: RTL

- Central pipeline sequencer for the 5-stage MIPS32 core (IF/ID/EX/MEM/WB).
- Inspects the instruction latched in IF/ID and in ID/EX, together with the EX branch condition.
- Drives per-stage register enables, flushes and the PC branch select.
- Handles load-use stalls, taken-branch squash, multi-cycle MUL occupancy of EX, and HLT drain-to-halt.

---
 rtl/mips32_pkg.sv | 50 +++++
 rtl/hazard_detect.sv | 28 ++
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, the NOP encoding, sequencer states and
// a register-read decoder used by hazard detection.
package mips32_pkg;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAnd   = 6'b000010;
    localparam logic [5:0] OpOr    = 6'b000011;
    localparam logic [5:0] OpSlt   = 6'b000100;
    localparam logic [5:0] OpMul   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b010000;
    localparam logic [5:0] OpSubi  = 6'b010001;
    localparam logic [5:0] OpAndi  = 6'b010010;
    localparam logic [5:0] OpOri   = 6'b010011;
    localparam logic [5:0] OpSlti  = 6'b010100;
    localparam logic [5:0] OpMuli  = 6'b010101;
    localparam logic [5:0] OpLw    = 6'b110000;
    localparam logic [5:0] OpSw    = 6'b110001;
    localparam logic [5:0] OpBneqz = 6'b110100;
    localparam logic [5:0] OpBeqz  = 6'b110101;
    localparam logic [5:0] OpHlt   = 6'b111111;

    localparam logic [31:0] Nop = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StMul,
        StDrain,
        StHalted
    } ctrl_state_e;

    // True when instruction ir sources register r as an operand.
    function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] r);
        logic [5:0] op;
        logic       rs_hit;
        logic       rt_hit;
        op     = ir[31:26];
        rs_hit = (ir[25:21] == r);
        rt_hit = (ir[20:16] == r);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul:          reads_reg = rs_hit | rt_hit;
            OpAddi, OpSubi, OpAndi, OpOri, OpSlti, OpMuli:    reads_reg = rs_hit;
            OpLw, OpBneqz, OpBeqz:                            reads_reg = rs_hit;
            OpSw:                                             reads_reg = rs_hit | rt_hit;
            default:                                          reads_reg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classification of the instructions sitting in ID and EX.
module hazard_detect
    import mips32_pkg::*;
(
    input  logic [31:0] ir_if_id_i,
    input  logic [31:0] ir_id_ex_i,
    input  logic        cond_ex_i,
    output logic        load_use_o,
    output logic        branch_taken_o,
    output logic        mul_in_ex_o,
    output logic        hlt_in_id_o
);

    logic [5:0] op_id;
    logic [5:0] op_ex;
    logic [4:0] rt_ex;

    assign op_id = ir_if_id_i[31:26];
    assign op_ex = ir_id_ex_i[31:26];
    assign rt_ex = ir_id_ex_i[20:16];

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    assign load_use_o     = (op_ex == OpLw) && (rt_ex != 5'd0) && reads_reg(ir_if_id_i, rt_ex);
    assign branch_taken_o = ((op_ex == OpBneqz) || (op_ex == OpBeqz)) && cond_ex_i;
    assign mul_in_ex_o    = (op_ex == OpMul);
    assign hlt_in_id_o    = (op_id == OpHlt);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables/flushes, branch select, MUL occupancy and
// HLT drain-to-halt for the 5-stage MIPS32 core.
module pipe_ctrl
    import mips32_pkg::*;
#(
    parameter int unsigned MUL_LAT      = 3,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] IR_if_id,
    input  logic [31:0] IR_id_ex,
    input  logic        cond_ex,
    output logic        pc_en,
    output logic        pc_sel_br,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        ex_mem_flush,
    output logic        mem_wb_en,
    output logic        halted,
    output logic [15:0] stall_count
);

    localparam int unsigned CntMax = (MUL_LAT > DRAIN_CYCLES) ? MUL_LAT : DRAIN_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    ctrl_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     stall_count_q, stall_count_d;

    logic load_use;
    logic branch_taken;
    logic mul_in_ex;
    logic hlt_in_id;

    hazard_detect u_hazard_detect (
        .ir_if_id_i     (IR_if_id),
        .ir_id_ex_i     (IR_id_ex),
        .cond_ex_i      (cond_ex),
        .load_use_o     (load_use),
        .branch_taken_o (branch_taken),
        .mul_in_ex_o    (mul_in_ex),
        .hlt_in_id_o    (hlt_in_id)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b0;
        pc_sel_br    = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                if (mul_in_ex && (MUL_LAT > 1)) begin
                    // Freeze front end; bubble into MEM while EX is busy.
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                    cnt_d        = CntW'(MUL_LAT - 2);
                    state_d      = StMul;
                end else if (branch_taken) begin
                    pc_sel_br   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (hlt_in_id) begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    cnt_d       = CntW'(DRAIN_CYCLES - 1);
                    state_d     = StDrain;
                end
            end
            StMul: begin
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                if (cnt_q != '0) begin
                    ex_mem_flush = 1'b1;
                    cnt_d        = cnt_q - CntW'(1);
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    id_ex_en = 1'b1;
                    state_d  = StRun;
                end
            end
            StDrain: begin
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StHalted;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (((state_q == StRun) || (state_q == StMul)) && !pc_en &&
            (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
